// File: rtl/tmr_error_logger_if.sv
// tmr_error_logger_if: sample, log-reader and status signals of the TMR error logger.
// master = TMR stage plus host reader side, slave = logger.
interface tmr_error_logger_if #(
   parameter int DATA_LEN = 8,
   parameter int CNT_W    = 8
);
   logic [DATA_LEN-1:0] data_in;
   logic                TMR_error;
   logic                sample_en;
   logic                clear;
   logic [DATA_LEN-1:0] log_data;
   logic [CNT_W-1:0]    log_stamp;
   logic                log_valid;
   logic                log_ready;
   logic [CNT_W-1:0]    err_count;
   logic                alarm;
   logic                overflow;
   modport master (
      output data_in, TMR_error, sample_en, clear, log_ready,
      input  log_data, log_stamp, log_valid, err_count, alarm, overflow
   );
   modport slave (
      input  data_in, TMR_error, sample_en, clear, log_ready,
      output log_data, log_stamp, log_valid, err_count, alarm, overflow
   );
endinterface

// File: rtl/tmr_error_logger.sv
// tmr_error_logger: counts voted error samples, logs {stamp, data} into an FWFT FIFO
// and raises a sticky alarm after ALARM_THRESH consecutive error samples.
module tmr_error_logger #(
   parameter int DATA_LEN     = 8,
   parameter int DEPTH        = 4,
   parameter int CNT_W        = 8,
   parameter int ALARM_THRESH = 3
) (
   input logic                 clk,
   input logic                 reset,
   tmr_error_logger_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;
   logic [DATA_LEN-1:0] r_data [DEPTH];
   logic [CNT_W-1:0]    r_stamp_mem [DEPTH];
   logic [AW:0]         r_wptr, r_rptr;
   logic [CNT_W-1:0]    r_stamp, r_err_cnt, r_run_cnt;
   state_t              r_state;
   logic                r_alarm, r_ovf;
   logic                w_empty, w_full, w_pop, w_err, w_clean, w_push;
   logic [CNT_W-1:0]    w_run_nxt;
   assign w_empty   = r_wptr == r_rptr;
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop     = !w_empty && bus.log_ready;
   assign w_err     = bus.sample_en && bus.TMR_error;
   assign w_clean   = bus.sample_en && !bus.TMR_error;
   // a full FIFO still accepts when the head leaves in the same cycle
   assign w_push    = w_err && (!w_full || w_pop);
   assign w_run_nxt = (r_run_cnt == CNT_W'(ALARM_THRESH)) ? r_run_cnt : r_run_cnt + 1'b1;
   assign bus.log_valid = !w_empty;
   assign bus.log_data  = r_data[r_rptr[AW-1:0]];
   assign bus.log_stamp = r_stamp_mem[r_rptr[AW-1:0]];
   assign bus.err_count = r_err_cnt;
   assign bus.alarm     = r_alarm;
   assign bus.overflow  = r_ovf;
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i]      <= '0;
            r_stamp_mem[i] <= '0;
         end
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_stamp   <= '0;
         r_err_cnt <= '0;
         r_run_cnt <= '0;
         r_state   <= IDLE;
         r_alarm   <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_stamp <= r_stamp + 1'b1;
         if (w_push) begin
            r_data[r_wptr[AW-1:0]]      <= bus.data_in;
            r_stamp_mem[r_wptr[AW-1:0]] <= r_stamp;
            r_wptr                      <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         // clear wins over the counters and FSM, but the FIFO push above still happens
         if (bus.clear) begin
            r_err_cnt <= '0;
            r_run_cnt <= '0;
            r_ovf     <= 1'b0;
            r_state   <= IDLE;
            r_alarm   <= 1'b0;
         end else if (w_err) begin
            if (!w_push) r_ovf <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            r_run_cnt <= w_run_nxt;
            if (w_run_nxt == CNT_W'(ALARM_THRESH)) begin
               r_state <= ALARM;
               r_alarm <= 1'b1;
            end else if (r_state != ALARM) r_state <= RUN;
         end else if (w_clean) begin
            r_run_cnt <= '0;
            if (r_state != ALARM) r_state <= IDLE;
         end
      end
   end
endmodule
